// File: rtl/demux_pkg.sv
// demux_pkg
// Shared definitions for the 1-to-4 demultiplexer dispatcher.
//   NUM_CH     : number of output channels
//   CH_W       : width of a channel index
//   MODE_FIXED : mode value selecting the fixed channel given by sel
//   MODE_RR    : mode value selecting round-robin bursts
//   state_t    : output-register occupancy (EMPTY / FULL)
package demux_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/demux4_onehot.sv
// demux4_onehot
// Expands a channel index into a one-hot valid vector.
//   ch     : selected channel (0..3)
//   en     : word present; when low the vector is all zeros
//   onehot : bit ch set when en is high, never more than one bit set
module demux4_onehot
  import demux_pkg::*;
(
  input  logic [CH_W-1:0]   ch,
  input  logic              en,
  output logic [NUM_CH-1:0] onehot
);

  // Start from all-zero so an idle output register raises no valid at all.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[ch] = 1'b1;
    end
  end

endmodule

// File: rtl/demux4_dispatcher.sv
// demux4_dispatcher
// Steers a valid/ready word stream to one of four channels through a
// one-word output register, in fixed-channel or round-robin burst mode,
// and keeps a saturating delivered-word counter per channel.
//   clk, rst_n          : clock, asynchronous active-low reset
//   mode, sel           : 0 = fixed channel sel, 1 = round-robin
//   in_valid/in_ready   : input handshake, in_data the word
//   out_valid/out_ready : per-channel one-hot valid and sink ready
//   out_data            : shared output bus for the asserted channel
//   cnt_clr, cnt        : counter clear, packed counters (channel i at i*CNT_W)
//   rr_ptr              : current round-robin channel
module demux4_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int BURST  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [1:0]              sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic [3:0]              out_valid,
  input  logic [3:0]              out_ready,
  output logic [DATA_W-1:0]       out_data,
  input  logic                    cnt_clr,
  output logic [4*CNT_W-1:0]      cnt,
  output logic [1:0]              rr_ptr
);

  localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

  state_t           state_q, state_d;
  logic [CH_W-1:0]  ch_q;
  logic [DATA_W-1:0] data_q;
  logic [CH_W-1:0]  rr_q;
  logic [7:0]       burst_q;
  logic [7:0]       burst_eff;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q [NUM_CH];
  logic             accept;
  logic             drain;
  logic             rr_entry;
  logic [CH_W-1:0]  target;

  // The register can take a new word whenever it is empty or the word it
  // holds leaves this same cycle, which gives one word per cycle sustained.
  assign in_ready  = (state_q == EMPTY) | out_ready[ch_q];
  assign accept    = in_valid & in_ready;
  assign drain     = (state_q == FULL) & out_ready[ch_q];
  assign rr_entry  = (mode == MODE_RR) & (mode_q == MODE_FIXED);
  assign burst_eff = rr_entry ? 8'd0 : burst_q;
  assign target    = (mode == MODE_RR) ? rr_q : sel;

  assign out_data = data_q;
  assign rr_ptr   = rr_q;

  demux4_onehot u_onehot (
    .ch     (ch_q),
    .en     (state_q == FULL),
    .onehot (out_valid)
  );

  // State register for the output-register occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: an accept always leaves the register full (even when the
  // old word drains in the same cycle); a drain alone empties it.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = FULL;
    end else if (drain) begin
      state_d = EMPTY;
    end
  end

  // Held word and its channel are latched only on accept, so later sel or
  // mode changes cannot retarget a word that is already waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      data_q <= '0;
    end else if (accept) begin
      ch_q   <= target;
      data_q <= in_data;
    end
  end

  // Round-robin bookkeeping. Entering round-robin mode restarts the burst
  // but keeps the pointer; the pointer never skips a stalled sink because
  // it only moves on accepted words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= '0;
      burst_q <= '0;
      mode_q  <= MODE_FIXED;
    end else begin
      mode_q <= mode;
      if (accept && (mode == MODE_RR)) begin
        if (burst_eff == BURST_LAST) begin
          burst_q <= 8'd0;
          rr_q    <= rr_q + 2'd1;
        end else begin
          burst_q <= burst_eff + 8'd1;
        end
      end else if (rr_entry) begin
        burst_q <= 8'd0;
      end
    end
  end

  // Delivered-word counters: saturate at all-ones, and a clear beats an
  // increment landing in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cnt_clr) begin
          cnt_q[i] <= '0;
        end else if (drain && (ch_q == CH_W'(i)) && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
    assign cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: doc/demux4_dispatcher.md
# demux4_dispatcher

Sequenced front end for the 1-to-4 demultiplexer datapath. Accepts a single valid/ready word stream and steers each word to one of four output channels, either to a fixed channel selected by configuration or round-robin in bursts of BURST words. A one-word output register decouples the input from the selected sink. The block also keeps per-channel delivered-word counters for status readback. It sits between the upstream producer and four independent consumers.

## Interface
- DATA_W, 8, width of the data word
- BURST, 4, words sent to one channel before round-robin advances (1..255)
- CNT_W, 16, width of each per-channel delivered-word counter
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- mode  in  1  0 = fixed channel (sel), 1 = round-robin
- sel  in  2  fixed-mode target channel (0..3)
- in_valid  in  1  input word valid
- in_ready  out  1  input word accepted when in_valid & in_ready
- in_data  in  DATA_W  input word
- out_valid  out  4  one-hot; bit i = word presented to channel i
- out_ready  in  4  per-channel sink ready
- out_data  out  DATA_W  shared output data bus, valid for the asserted channel
- cnt_clr  in  1  synchronous clear of all delivered counters
- cnt  out  4*CNT_W  delivered-word counters, channel i at bits [i*CNT_W +: CNT_W]
- rr_ptr  out  2  current round-robin channel, for status

## Operation
- States: EMPTY (output register empty), FULL (word held for channel ch).
- in_ready = (state==EMPTY) | out_ready[ch]; registered word replaced in the same cycle it drains.
- Accept: EMPTY -> FULL, or FULL -> FULL with simultaneous drain; latch in_data into out_data and target into ch.
- Target at accept: mode=0 -> sel sampled that cycle; mode=1 -> rr_ptr.
- Drain: FULL and out_ready[ch] and no accept -> EMPTY.
- out_valid = 4'b0001 << ch when FULL, else 4'b0000; never more than one bit set.
- Round-robin: burst_cnt counts accepted words in mode=1; on the accept that makes burst_cnt = BURST, burst_cnt -> 0 and rr_ptr -> rr_ptr+1 mod 4 (3 wraps to 0).
- rr_ptr does not skip channels whose sink is not ready; the stream stalls until that sink accepts.
- Mode 0 does not modify rr_ptr or burst_cnt. A 0->1 transition of mode clears burst_cnt. rr_ptr is kept.
- sel or mode changes never retarget a word already held; they apply only to the next accept.
- Counters: cnt[i] increments on each drain to channel i. The counter saturates at all-ones.
- cnt_clr zeroes all counters. cnt_clr wins over a same-cycle increment.
- Reset (any time, including mid-transfer): state=EMPTY, out_valid=0, out_data=0, ch=0, rr_ptr=0, burst_cnt=0, all cnt=0. A held word is discarded.
- in_ready is 1 from the first cycle after reset deassertion.

## Timing
- Latency: word accepted at edge N appears on out_valid/out_data after edge N, so it can drain at edge N+1.
- Throughput: one word per cycle sustained while the target sink holds out_ready high.
- in_ready depends combinationally on out_ready[ch]. All other outputs come straight from flops.
- out_data and ch are stable while FULL and not draining.

## Structure
- Shared package demux_pkg:
  - NUM_CH = 4
  - CH_W = 2
  - mode encoding constants MODE_FIXED = 0, MODE_RR = 1
- Sub-module demux4_onehot:
  - inputs: 2-bit channel and enable
  - output: 4-bit one-hot, equal to out_valid
- Everything else stays in demux4_dispatcher:
  - state and handshake control
  - round-robin pointer and burst counter
  - counter bank

## Test plan
- Reset mid-transfer: assert rst_n=0 while FULL for ch=2 -> out_valid=0000, in_ready=1 after release, cnt all 0, rr_ptr=0.
- Fixed mode: mode=0, sel=1, all out_ready=1, stream 0x10..0x13 -> out_valid=0010 for 4 consecutive cycles carrying 0x10..0x13, cnt[1]=4, rr_ptr stays 0.
- Round-robin wrap: mode=1, BURST=4, all ready, 16 words -> 4 each to ch0,1,2,3 in order; rr_ptr back to 0; each cnt=4.
- Backpressure: mode=1, out_ready[0]=0 for 5 cycles with in_valid=1 -> one word held on ch0, in_ready=0 for those cycles, no word lost or duplicated, then resumes one word per cycle.
- Mode switch: in mode=1 after 2 words on ch0, switch to mode=0 with sel=3 for 3 words, then back to mode=1 -> 3 words go to ch3, burst restarts, 4 more words go to ch0.
- Counter saturation/clear: CNT_W=4, 17 words to ch2 -> cnt[2]=15. cnt_clr together with a drain -> cnt[2]=0.
